correlator_cfg_ctrl: RTL and testbench

CORRELATOR_CFG_CTRL -- requirements
Module: correlator_cfg_ctrl

---
 rtl/correlator_cfg_pkg.sv | 28 ++
 rtl/correlator_cfg_ctrl_if.sv | 10 +
 rtl/correlator_cfg_ctrl.sv | 148 ++++++++++++++
 tb/tb_correlator_cfg_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/correlator_cfg_pkg.sv
// Shared opcode constants, commit-FSM state type and opcode classifiers
// for the correlator configuration controller.
package correlator_cfg_pkg;

    localparam logic [3:0] OP_CLEAR          = 4'h0;
    localparam logic [3:0] OP_SET_INDEX      = 4'h1;
    localparam logic [3:0] OP_SET_LEDS       = 4'h2;
    localparam logic [3:0] OP_SET_BAUD_RATE  = 4'h3;
    localparam logic [3:0] OP_SET_DELAY      = 4'h4;
    localparam logic [3:0] OP_SET_FREQ_DIV   = 4'h8;
    localparam logic [3:0] OP_ENABLE_CAPTURE = 4'hD;

    typedef enum logic {
        CFG_CLEAN = 1'b0,
        CFG_DIRTY = 1'b1
    } cfg_state_t;

    // Opcodes 4-7: nibble writes; opcode[1:0] selects the nibble.
    function automatic logic is_delay_op(input logic [3:0] op);
        return op[3:2] == OP_SET_DELAY[3:2];
    endfunction

    // Opcodes 8-11: opcode[1:0] supplies the divider's upper two bits.
    function automatic logic is_freq_div_op(input logic [3:0] op);
        return op[3:2] == OP_SET_FREQ_DIV[3:2];
    endfunction

endpackage

// File: rtl/correlator_cfg_ctrl_if.sv
// Command-byte channel from the UART receiver into the config controller.
interface correlator_cfg_ctrl_if;

    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output rx_data, output rx_valid);
    modport slave  (input  rx_data, input  rx_valid);

endinterface

// File: rtl/correlator_cfg_ctrl.sv
// Correlator configuration controller: decodes command bytes into shadow
// registers and commits them atomically on integration boundaries.
module correlator_cfg_ctrl
    import correlator_cfg_pkg::*;
#(
    parameter int unsigned NUM_INPUTS  = 8,
    parameter int unsigned DELAY_SIZE  = 200,
    parameter int unsigned DELAY_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    correlator_cfg_ctrl_if.slave              rx,
    input  logic                              integration_tick,
    output logic [NUM_INPUTS*DELAY_WIDTH-1:0] delay_flat,
    output logic [31:0]                       leds,
    output logic [3:0]                        baud_rate,
    output logic [5:0]                        clock_divider,
    output logic                              transmit_enable,
    output logic                              cfg_update,
    output logic                              cfg_pending,
    output logic [7:0]                        err_count
);

    localparam logic [DELAY_WIDTH-1:0] DELAY_MAX = DELAY_WIDTH'(DELAY_SIZE - 1);

    logic [DELAY_WIDTH-1:0] shadow_delay  [NUM_INPUTS];
    logic [DELAY_WIDTH-1:0] active_delay  [NUM_INPUTS];
    logic [DELAY_WIDTH-1:0] clamped_delay [NUM_INPUTS];
    logic [3:0]             index;
    logic [5:0]             shadow_div;
    logic                   shadow_te;
    cfg_state_t             state;

    logic [3:0] opcode;
    logic [3:0] arg;
    logic       index_ok;
    logic       cmd_bad;
    logic       cmd_shadow;
    logic       commit_changes;
    logic       do_commit;

    assign opcode      = rx.rx_data[3:0];
    assign arg         = rx.rx_data[7:4];
    assign index_ok    = 32'(index) < NUM_INPUTS;
    assign do_commit   = integration_tick && (state == CFG_DIRTY);
    assign cfg_pending = (state == CFG_DIRTY);

    always_comb begin
        cmd_bad    = 1'b0;
        cmd_shadow = 1'b0;
        if (is_delay_op(opcode) || opcode == OP_CLEAR) begin
            cmd_bad    = !index_ok;
            cmd_shadow = index_ok;
        end else if (is_freq_div_op(opcode) || opcode == OP_ENABLE_CAPTURE) begin
            cmd_shadow = 1'b1;
        end else if (opcode != OP_SET_INDEX && opcode != OP_SET_LEDS &&
                     opcode != OP_SET_BAUD_RATE) begin
            cmd_bad = 1'b1;
        end
    end

    // Clamp happens on the commit path only; shadows keep the raw value.
    always_comb begin
        commit_changes = (shadow_div != clock_divider) || (shadow_te != transmit_enable);
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            clamped_delay[i] = (shadow_delay[i] > DELAY_MAX) ? DELAY_MAX : shadow_delay[i];
            if (clamped_delay[i] != active_delay[i]) begin
                commit_changes = 1'b1;
            end
        end
    end

    always_comb begin
        delay_flat = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            delay_flat[i*DELAY_WIDTH +: DELAY_WIDTH] = active_delay[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                shadow_delay[i] <= '0;
                active_delay[i] <= '0;
            end
            index           <= '0;
            leds            <= '0;
            baud_rate       <= '0;
            shadow_div      <= '0;
            clock_divider   <= '0;
            shadow_te       <= 1'b0;
            transmit_enable <= 1'b0;
            err_count       <= '0;
            cfg_update      <= 1'b0;
            state           <= CFG_CLEAN;
        end else begin
            cfg_update <= 1'b0;

            // Commit reads pre-write shadows; a same-cycle write re-dirties below.
            if (do_commit) begin
                for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                    active_delay[i] <= clamped_delay[i];
                end
                clock_divider   <= shadow_div;
                transmit_enable <= shadow_te;
                cfg_update      <= commit_changes;
                state           <= CFG_CLEAN;
            end

            if (rx.rx_valid) begin
                if (cmd_bad) begin
                    if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                end else begin
                    case (opcode)
                        OP_CLEAR: begin
                            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                                if (32'(index) == i) begin
                                    shadow_delay[i] <= '0;
                                end
                            end
                        end
                        OP_SET_INDEX:      index <= arg;
                        OP_SET_LEDS:       leds[{index, 1'b0} +: 2] <= arg[1:0];
                        OP_SET_BAUD_RATE:  baud_rate <= arg;
                        OP_ENABLE_CAPTURE: shadow_te <= arg[0];
                        default: begin
                            if (is_delay_op(opcode)) begin
                                for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                                    if (32'(index) == i) begin
                                        shadow_delay[i][{opcode[1:0], 2'b00} +: 4] <= arg;
                                    end
                                end
                            end else if (is_freq_div_op(opcode)) begin
                                shadow_div <= {opcode[1:0], arg};
                            end
                        end
                    endcase
                end
                if (cmd_shadow) begin
                    state <= CFG_DIRTY;
                end
            end
        end
    end

endmodule

// File: tb/tb_correlator_cfg_ctrl.sv
// Directed scenarios plus randomized command traffic for correlator_cfg_ctrl,
// checked every cycle against an array-based behavioural model.
module tb_correlator_cfg_ctrl;

    localparam int unsigned NI = 8;
    localparam int unsigned DS = 200;
    localparam int unsigned DW = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             integration_tick;
    logic [NI*DW-1:0] delay_flat;
    logic [31:0]      leds;
    logic [3:0]       baud_rate;
    logic [5:0]       clock_divider;
    logic             transmit_enable;
    logic             cfg_update;
    logic             cfg_pending;
    logic [7:0]       err_count;

    correlator_cfg_ctrl_if rx ();

    correlator_cfg_ctrl #(
        .NUM_INPUTS (NI),
        .DELAY_SIZE (DS),
        .DELAY_WIDTH(DW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rx              (rx),
        .integration_tick(integration_tick),
        .delay_flat      (delay_flat),
        .leds            (leds),
        .baud_rate       (baud_rate),
        .clock_divider   (clock_divider),
        .transmit_enable (transmit_enable),
        .cfg_update      (cfg_update),
        .cfg_pending     (cfg_pending),
        .err_count       (err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Behavioural model state
    int unsigned m_sh [NI];
    int unsigned m_ac [NI];
    int unsigned m_idx, m_baud, m_sdiv, m_adiv, m_ste, m_ate, m_err;
    logic [31:0] m_leds;
    bit          m_dirty, m_upd;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic void model_err();
        if (m_err < 255) m_err++;
    endfunction

    function automatic void model_step(bit rst, bit v, logic [7:0] d, bit tk);
        int unsigned op, arg, nv, n;
        if (rst) begin
            for (int i = 0; i < NI; i++) begin m_sh[i] = 0; m_ac[i] = 0; end
            m_idx = 0; m_baud = 0; m_sdiv = 0; m_adiv = 0; m_ste = 0; m_ate = 0;
            m_err = 0; m_leds = '0; m_dirty = 0; m_upd = 0;
            return;
        end
        m_upd = 0;
        if (tk && m_dirty) begin
            for (int i = 0; i < NI; i++) begin
                nv = (m_sh[i] < DS - 1) ? m_sh[i] : DS - 1;
                if (nv != m_ac[i]) m_upd = 1;
                m_ac[i] = nv;
            end
            if (m_adiv != m_sdiv || m_ate != m_ste) m_upd = 1;
            m_adiv  = m_sdiv;
            m_ate   = m_ste;
            m_dirty = 0;
        end
        if (!v) return;
        op  = int'(d) % 16;
        arg = int'(d) / 16;
        if (op == 0 || (op >= 4 && op <= 7)) begin
            if (m_idx >= NI) model_err();
            else begin
                if (op == 0) m_sh[m_idx] = 0;
                else begin
                    n = op - 4;
                    m_sh[m_idx] = (m_sh[m_idx] & ~(32'hF << (4 * n))) | (arg << (4 * n));
                end
                m_dirty = 1;
            end
        end else if (op == 1) m_idx = arg;
        else if (op == 2) m_leds[m_idx*2 +: 2] = 2'(arg);
        else if (op == 3) m_baud = arg;
        else if (op >= 8 && op <= 11) begin m_sdiv = (op - 8) * 16 + arg; m_dirty = 1; end
        else if (op == 13) begin m_ste = arg % 2; m_dirty = 1; end
        else model_err();
    endfunction

    task automatic check_all();
        logic [NI*DW-1:0] exp_flat;
        exp_flat = '0;
        for (int i = 0; i < NI; i++) exp_flat[i*DW +: DW] = DW'(m_ac[i]);
        chk("delay_flat", 256'(delay_flat), 256'(exp_flat));
        chk("leds", 256'(leds), 256'(m_leds));
        chk("baud_rate", 256'(baud_rate), 256'(m_baud));
        chk("clock_divider", 256'(clock_divider), 256'(m_adiv));
        chk("transmit_enable", 256'(transmit_enable), 256'(m_ate));
        chk("cfg_update", 256'(cfg_update), 256'(m_upd));
        chk("cfg_pending", 256'(cfg_pending), 256'(m_dirty));
        chk("err_count", 256'(err_count), 256'(m_err));
    endtask

    task automatic step(input bit rst, input bit v, input logic [7:0] d, input bit tk);
        @(negedge clk);
        reset            = rst;
        rx.rx_valid      = v;
        rx.rx_data       = d;
        integration_tick = tk;
        @(posedge clk);
        model_step(rst, v, d, tk);
        #1;
        reset            = 1'b0;
        rx.rx_valid      = 1'b0;
        integration_tick = 1'b0;
        check_all();
    endtask

    task automatic cmd(input logic [7:0] d);
        step(0, 1, d, 0);
    endtask

    task automatic tick();
        step(0, 0, 8'h00, 1);
    endtask

    initial begin
        logic [3:0] op, arg;
        bit         r, v, t;

        reset = 1'b1; rx.rx_valid = 1'b0; rx.rx_data = '0; integration_tick = 1'b0;
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        chk("reset_pending", 256'(cfg_pending), 256'(0));

        // Nibble writes stay in shadow until a tick, then commit once.
        cmd(8'h21); cmd(8'h34); cmd(8'h25); cmd(8'h06);
        chk("shadow_not_active", 256'(delay_flat[2*DW +: DW]), 256'(0));
        tick();
        chk("commit_pulse", 256'(cfg_update), 256'(1));
        step(0, 0, 8'h00, 0);
        chk("pulse_one_cycle", 256'(cfg_update), 256'(0));
        tick();
        chk("clean_tick_noop", 256'(cfg_update), 256'(0));

        // Shadow 0x0FFF clamps to DELAY_SIZE-1.
        cmd(8'h01); cmd(8'hF4); cmd(8'hF5); cmd(8'hF6); cmd(8'h07);
        tick();
        chk("clamp_max", 256'(delay_flat[DW-1:0]), 256'(DS - 1));

        // Tick colliding with a write commits the old shadow and stays dirty.
        cmd(8'h1D);
        step(0, 1, 8'h0D, 1);
        chk("collide_te", 256'(transmit_enable), 256'(1));
        chk("collide_pending", 256'(cfg_pending), 256'(1));
        tick();
        chk("second_tick_te", 256'(transmit_enable), 256'(0));

        // Rejected commands and err_count saturation.
        step(1, 0, 8'h00, 0);
        cmd(8'h91); cmd(8'h04); cmd(8'h0C); cmd(8'h0F);
        chk("err_three", 256'(err_count), 256'(3));
        chk("err_no_dirty", 256'(cfg_pending), 256'(0));
        for (int i = 0; i < 260; i++) cmd(8'hFC);
        chk("err_saturate", 256'(err_count), 256'(255));

        // Immediate LED and baud writes.
        cmd(8'hF1); cmd(8'h32);
        chk("leds_top", 256'(leds[31:30]), 256'(2'b11));
        cmd(8'h53);
        chk("baud_now", 256'(baud_rate), 256'(5));

        // Reset wins over a tick while dirty.
        cmd(8'h01); cmd(8'h34); cmd(8'h19);
        step(1, 0, 8'h00, 1);
        chk("rst_tick_update", 256'(cfg_update), 256'(0));
        chk("rst_tick_delay", 256'(delay_flat), 256'(0));
        chk("rst_tick_div", 256'(clock_divider), 256'(0));

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            r   = ($urandom_range(0, 149) == 0);
            v   = ($urandom_range(0, 3) != 0);
            t   = ($urandom_range(0, 4) == 0);
            op  = 4'($urandom_range(0, 15));
            arg = 4'($urandom_range(0, 15));
            if (op == 4'h1 && $urandom_range(0, 3) != 0) arg = 4'($urandom_range(0, NI - 1));
            step(r, v, {arg, op}, t);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
